// File: rtl/score_pkg.sv
// score_pkg: shared score constants, match states and the win rule
// for the pong match controller.
package score_pkg;

   localparam int SCORE_W_DEF   = 4;
   localparam int MAX_SCORE_DEF = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_PAUSE = 3'd4,
      ST_OVER  = 3'd5
   } match_state_e;

   // A saturated score with any lead wins, so play cannot stall at the top.
   function automatic logic win_check(
      input int s,
      input int o,
      input int max_s,
      input int lead,
      input int sat
   );
      return ((s >= max_s) && ((s - o) >= lead)) ||
             ((s == sat) && (s > o));
   endfunction

   function automatic int max3(
      input int a,
      input int b,
      input int c
   );
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/frame_delay_cnt.sv
// frame_delay_cnt: loadable frame-tick down-counter with hold;
// done pulses on the tick that takes the count from 1 to 0.
module frame_delay_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         hold,
   output logic         done
);

   logic [W-1:0] count;

   assign done = tick && !hold && (count == W'(1));

   // A load wins over a coincident tick, so entry ticks never count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && !hold && (count != '0)) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/game_match_fsm.sv
// game_match_fsm: pong match controller owning scores, serve
// sequencing, pause and game-over/winner reporting.
module game_match_fsm
   import score_pkg::*;
#(
   parameter int SCORE_W      = SCORE_W_DEF,
   parameter int MAX_SCORE    = MAX_SCORE_DEF,
   parameter int WIN_BY_TWO   = 0,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int OVER_FRAMES  = 180
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               frame_tick_i,
   input  logic               start_i,
   input  logic               pause_i,
   input  logic               p_point_i,
   input  logic               e_point_i,
   output logic [SCORE_W-1:0] p_score_o,
   output logic [SCORE_W-1:0] e_score_o,
   output logic               game_en_o,
   output logic               serve_dir_o,
   output logic               game_over_o,
   output logic               winner_o,
   output logic [2:0]         state_o
);

   localparam int MAX_F = max3(SERVE_FRAMES, POINT_FRAMES, OVER_FRAMES);
   localparam int CNT_W = $clog2(MAX_F + 1);
   localparam int LEAD  = (WIN_BY_TWO != 0) ? 2 : 1;
   localparam int SAT   = (1 << SCORE_W) - 1;

   match_state_e state;
   match_state_e ret_state;

   logic             start_go;
   logic             pause_go;
   logic             pt_p;
   logic             pt_e;
   logic             pt_both;
   logic             win_p;
   logic             win_e;
   logic             load;
   logic             hold;
   logic             done;
   logic [CNT_W-1:0] load_val;

   function automatic logic [SCORE_W-1:0] sat_inc(
      input logic [SCORE_W-1:0] v
   );
      return (v == '1) ? v : v + SCORE_W'(1);
   endfunction

   assign state_o = state;

   // start and pause are legal in disjoint states, so they never collide.
   always_comb begin
      start_go = start_i &&
                 ((state == ST_IDLE) || (state == ST_OVER));
      pause_go = pause_i &&
                 (state inside {ST_SERVE, ST_PLAY, ST_POINT, ST_PAUSE});
      pt_both  = (state == ST_PLAY) && !pause_go &&
                 p_point_i && e_point_i;
      pt_p     = (state == ST_PLAY) && !pause_go &&
                 p_point_i && !e_point_i;
      pt_e     = (state == ST_PLAY) && !pause_go &&
                 e_point_i && !p_point_i;
      win_p    = win_check(int'(p_score_o), int'(e_score_o),
                           MAX_SCORE, LEAD, SAT);
      win_e    = win_check(int'(e_score_o), int'(p_score_o),
                           MAX_SCORE, LEAD, SAT);
      hold     = (state == ST_PAUSE) || pause_go;
   end

   always_comb begin
      load     = 1'b0;
      load_val = '0;
      if (start_go || pt_both) begin
         load     = 1'b1;
         load_val = CNT_W'(SERVE_FRAMES);
      end else if (pt_p || pt_e) begin
         load     = 1'b1;
         load_val = CNT_W'(POINT_FRAMES);
      end else if ((state == ST_POINT) && done) begin
         load     = 1'b1;
         load_val = (win_p || win_e) ? CNT_W'(OVER_FRAMES)
                                     : CNT_W'(SERVE_FRAMES);
      end
   end

   frame_delay_cnt #(
      .W(CNT_W)
   ) u_delay (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .tick     (frame_tick_i),
      .load     (load),
      .load_val (load_val),
      .hold     (hold),
      .done     (done)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         ret_state   <= ST_IDLE;
         p_score_o   <= '0;
         e_score_o   <= '0;
         game_en_o   <= 1'b0;
         serve_dir_o <= 1'b0;
         game_over_o <= 1'b0;
         winner_o    <= 1'b0;
      end else begin
         game_en_o   <= (state == ST_PLAY);
         game_over_o <= (state == ST_OVER);
         if (start_go) begin
            state       <= ST_SERVE;
            p_score_o   <= '0;
            e_score_o   <= '0;
            serve_dir_o <= 1'b0;
            winner_o    <= 1'b0;
         end else if (pause_go) begin
            if (state == ST_PAUSE) begin
               state <= ret_state;
            end else begin
               ret_state <= state;
               state     <= ST_PAUSE;
            end
         end else begin
            unique case (state)
               ST_SERVE: begin
                  if (done) state <= ST_PLAY;
               end
               ST_PLAY: begin
                  unique case (1'b1)
                     pt_both: state <= ST_SERVE;
                     pt_p: begin
                        p_score_o   <= sat_inc(p_score_o);
                        serve_dir_o <= 1'b1;
                        state       <= ST_POINT;
                     end
                     pt_e: begin
                        e_score_o   <= sat_inc(e_score_o);
                        serve_dir_o <= 1'b0;
                        state       <= ST_POINT;
                     end
                     default: ;
                  endcase
               end
               ST_POINT: begin
                  if (done) begin
                     if (win_p || win_e) begin
                        state    <= ST_OVER;
                        winner_o <= win_e;
                     end else begin
                        state <= ST_SERVE;
                     end
                  end
               end
               ST_OVER: begin
                  if (done) state <= ST_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
